// File: rtl/control_fsm.sv
// Four-state control sequencer for a simple bus-based processor: fetches a
// 9-bit instruction into IR and issues one-hot register/bus controls per step.
module control_fsm (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] din,
    output logic        irin,
    output logic [7:0]  rin,
    output logic [7:0]  rout,
    output logic        gout,
    output logic        dinout,
    output logic        ain,
    output logic        gin,
    output logic        sub,
    output logic        done
);

    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [8:0] ir_q;
    logic [2:0] opcode_s;
    logic [2:0] x_s;
    logic [2:0] y_s;

    function automatic logic [7:0] dec3(input logic [2:0] idx);
        return 8'h01 << idx;
    endfunction

    assign opcode_s = ir_q[8:6];
    assign x_s      = ir_q[5:3];
    assign y_s      = ir_q[2:0];

    // State and instruction register update
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= T0;
            ir_q    <= 9'h000;
        end else begin
            state_q <= state_d;
            if (irin) begin
                ir_q <= din[8:0];
            end else begin
                ir_q <= ir_q;
            end
        end
    end

    // Next-state sequencing; only two-operand ALU ops walk through T2/T3
    always_comb begin
        state_d = state_q;
        case (state_q)
            T0: begin
                if (run) begin
                    state_d = T1;
                end else begin
                    state_d = T0;
                end
            end
            T1: begin
                if ((opcode_s == OP_ADD) || (opcode_s == OP_SUB)) begin
                    state_d = T2;
                end else begin
                    state_d = T0;
                end
            end
            T2:      state_d = T3;
            T3:      state_d = T0;
            default: state_d = T0;
        endcase
    end

    // Moore control decode; everything is held low while reset is asserted
    always_comb begin
        irin   = 1'b0;
        rin    = 8'h00;
        rout   = 8'h00;
        gout   = 1'b0;
        dinout = 1'b0;
        ain    = 1'b0;
        gin    = 1'b0;
        sub    = 1'b0;
        done   = 1'b0;
        if (reset) begin
            irin = 1'b0;
        end else begin
            case (state_q)
                T0: irin = run;
                T1: begin
                    case (opcode_s)
                        OP_MV: begin
                            rout = dec3(y_s);
                            rin  = dec3(x_s);
                            done = 1'b1;
                        end
                        OP_MVI: begin
                            dinout = 1'b1;
                            rin    = dec3(x_s);
                            done   = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            rout = dec3(x_s);
                            ain  = 1'b1;
                        end
                        default: done = 1'b1;
                    endcase
                end
                T2: begin
                    rout = dec3(y_s);
                    gin  = 1'b1;
                    if (opcode_s == OP_SUB) begin
                        sub = 1'b1;
                    end else begin
                        sub = 1'b0;
                    end
                end
                T3: begin
                    gout = 1'b1;
                    rin  = dec3(x_s);
                    done = 1'b1;
                end
                default: irin = 1'b0;
            endcase
        end
    end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 The block SHALL have the following ports, clock and reset first (name, direction, width, meaning):
REQ-002 clock  input  1  single system clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 run  input  1  start request; sampled only in state T0.
REQ-005 din  input  16  instruction/data bus input; din[8:6]=opcode, din[5:3]=X, din[2:0]=Y; din[15:9] ignored for decode.
REQ-006 irin  output  1  IR load enable.
REQ-007 rin  output  8  one-hot register-file load enable (bit n loads Rn).
REQ-008 rout  output  8  one-hot register-file drive-to-bus select.
REQ-009 gout  output  1  ALU result register G drives bus.
REQ-010 dinout  output  1  din drives bus.
REQ-011 ain  output  1  ALU operand register A load enable.
REQ-012 gin  output  1  ALU result register G load enable.
REQ-013 sub  output  1  ALU operation select: 0=add, 1=subtract.
REQ-014 done  output  1  instruction-complete pulse, one cycle wide.

Function
REQ-015 The block SHALL contain a 9-bit instruction register IR, loaded from din[8:0] on the rising edge when irin=1.
REQ-016 The block SHALL implement four states: T0 (fetch), T1, T2 and T3.
REQ-017 All control outputs SHALL be Moore-decoded from the current state and IR (exception: irin follows run in T0); unlisted outputs are 0 in every state.
REQ-018 T0: irin=run; if run=1, next state is T1, otherwise the FSM stays in T0.
REQ-019 T1, opcode 000 (mv Rx<-Ry): rout[Y]=1, rin[X]=1, done=1; next state is T0.
REQ-020 T1, opcode 001 (mvi Rx<-din): dinout=1, rin[X]=1, done=1; next state is T0.
REQ-021 T1, opcode 010/011 (add/sub): rout[X]=1, ain=1; next state is T2.
REQ-022 T2: rout[Y]=1, gin=1, sub=1 only when opcode=011; next state is T3.
REQ-023 T3: gout=1, rin[X]=1, done=1; next state is T0.
REQ-024 Opcodes 100-111 (undefined): T1 asserts done=1 only; next state is T0.
REQ-025 rin and rout SHALL each have at most one bit set in any cycle; X=Y is legal (e.g. add R1,R1).
REQ-026 Latency: mv, mvi and undefined opcodes take 2 cycles from run sampled; add and sub take 4 cycles.
REQ-027 run asserted in T1, T2 or T3 SHALL be ignored; it is not queued.
REQ-028 run held high continuously SHALL fetch back-to-back, with T0 immediately following the done cycle.
REQ-029 At most one of gout, dinout or any rout bit SHALL be asserted in any cycle (single bus driver).

Reset
REQ-030 When reset=1 at a rising edge, the state SHALL become T0 and IR SHALL become 9'h000.
REQ-031 While reset=1, all control outputs SHALL be forced to 0, including irin.
REQ-032 A reset asserted in T1, T2 or T3 SHALL abort the instruction with no done pulse; no rin write occurs from the cycle after reset is sampled.

Verification
REQ-033 mvi: din=16'h0050, run=1 in T0 -> T1: dinout=1, rin=8'h04, done=1; then back in T0.
REQ-034 add R0,R1: din=16'h0081 -> T1: rout=8'h01, ain=1; T2: rout=8'h02, gin=1, sub=0; T3: gout=1, rin=8'h01, done=1.
REQ-035 sub R3,R5: din=16'h00DD -> T1: rout=8'h08, ain=1; T2: rout=8'h20, gin=1, sub=1; T3: gout=1, rin=8'h08, done=1.
REQ-036 mv R7,R4: din=16'h003C -> T1: rout=8'h10, rin=8'h80, done=1; run pulsed during T1 is ignored and the FSM stays in T0 afterwards.
REQ-037 Reset mid-op: start add with din=16'h0081, assert reset in T2 -> next cycle in T0 with all outputs 0, no done pulse; run=0 keeps the FSM in T0.
REQ-038 Undefined opcode: din=16'h01FF -> T1: done=1, all other outputs 0; run held high -> back-to-back fetch with irin=1 in the following T0.
